// File: rtl/instruction_fetch_pipelined_if.sv
// Fetch-stage bus: instruction-memory port plus the IF/ID instruction interface
// consumed by the decoder (current word, two-deep history, branch decision).
interface instruction_fetch_pipelined_if #(
    parameter int unsigned ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_rdata;
    logic                  br_taken;
    logic                  uncond_br;
    logic [ADDR_WIDTH-1:0] pc_id;
    logic [31:0]           instruction;
    logic [31:0]           instr_one_clock_before;
    logic [31:0]           instr_two_clocks_before;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  br_taken,
        input  uncond_br,
        output pc_id,
        output instruction,
        output instr_one_clock_before,
        output instr_two_clocks_before
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output br_taken,
        output uncond_br,
        input  pc_id,
        input  instruction,
        input  instr_one_clock_before,
        input  instr_two_clocks_before
    );
endinterface

// File: rtl/instruction_fetch_pipelined.sv
// LEGv8 fetch/issue stage: owns the PC, latches IF/ID with a two-deep history,
// applies branches with one delay slot, and sequences start/drain/halt.
module instruction_fetch_pipelined #(
    parameter int unsigned           ADDR_WIDTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
    parameter logic [31:0]           HALT_WORD    = 32'h1400_0000,
    parameter int unsigned           DRAIN_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    instruction_fetch_pipelined_if.master bus,
    output logic [ADDR_WIDTH-1:0]         pc,
    output logic                          running,
    output logic                          halted,
    output logic [31:0]                   fetch_count
);

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned OFF26_W  = 26;
    localparam int unsigned OFF19_W  = 19;
    localparam logic [WORD_W-1:0] BUBBLE     = '1;
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      drain_cnt;
    logic [ADDR_WIDTH-1:0] id_pc;
    logic [WORD_W-1:0]     id_instr;
    logic [WORD_W-1:0]     hist_one;
    logic [WORD_W-1:0]     hist_two;

    logic [ADDR_WIDTH-1:0] br_off;
    logic [ADDR_WIDTH-1:0] br_target;
    logic [ADDR_WIDTH-1:0] pc_seq;
    logic                  id_is_halt;

    // Branch target is relative to the branch's own PC, which now sits in ID
    always_comb begin
        br_off = '0;
        if (bus.uncond_br) begin
            br_off = {{(ADDR_WIDTH - OFF26_W){id_instr[25]}}, id_instr[25:0]};
        end else begin
            br_off = {{(ADDR_WIDTH - OFF19_W){id_instr[23]}}, id_instr[23:5]};
        end
        br_target  = id_pc + (br_off << 2);
        pc_seq     = pc + ADDR_WIDTH'(4);
        id_is_halt = (id_instr == HALT_WORD);
    end

    assign bus.imem_addr               = pc;
    assign bus.pc_id                   = id_pc;
    assign bus.instruction             = id_instr;
    assign bus.instr_one_clock_before  = hist_one;
    assign bus.instr_two_clocks_before = hist_two;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            pc          <= RESET_PC;
            id_pc       <= '0;
            id_instr    <= BUBBLE;
            hist_one    <= BUBBLE;
            hist_two    <= BUBBLE;
            running     <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end

                RUN: begin
                    hist_two <= hist_one;
                    hist_one <= id_instr;
                    // Halt word has no delay slot: swallow it and freeze the PC
                    if (id_is_halt) begin
                        state     <= DRAIN;
                        id_instr  <= BUBBLE;
                        drain_cnt <= DRAIN_LOAD;
                    end else begin
                        id_instr <= bus.imem_rdata;
                        id_pc    <= pc;
                        if (bus.imem_rdata != BUBBLE) begin
                            fetch_count <= fetch_count + 32'(1);
                        end
                        pc <= bus.br_taken ? br_target : pc_seq;
                    end
                end

                DRAIN: begin
                    hist_two <= hist_one;
                    hist_one <= id_instr;
                    id_instr <= BUBBLE;
                    if (drain_cnt == '0) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end

                HALTED: begin
                    if (start) begin
                        state       <= RUN;
                        pc          <= RESET_PC;
                        id_pc       <= '0;
                        id_instr    <= BUBBLE;
                        hist_one    <= BUBBLE;
                        hist_two    <= BUBBLE;
                        fetch_count <= '0;
                        running     <= 1'b1;
                        halted      <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch_pipelined.md
Name:
instruction_fetch_pipelined

Overview:
- Fetch/issue stage of the pipelined LEGv8 CPU; the producer side of the decoder's instruction interface.
- Owns the PC, drives instruction memory and latches the IF/ID instruction.
- Supplies the decoder with the current instruction plus the two previous instructions, which the decoder uses for forwarding.
- Applies the decoder's branch decision with one architectural delay slot, and runs a start/drain/halt FSM.

Parameters:
ADDR_WIDTH, 64, PC and instruction-memory address width.
RESET_PC, 0, PC value after reset and on restart.
HALT_WORD, 32'h14000000, halt sentinel (B #0) that stops fetch when it reaches ID.
DRAIN_CYCLES, 4, number of bubble cycles issued after the halt word before halted asserts (1..15).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins fetch from IDLE or restarts from HALTED
imem_addr  out  ADDR_WIDTH  instruction-memory address (= pc)
imem_rdata  in  32  instruction word, combinational read of imem_addr
br_taken  in  1  decoder BrTaken for the instruction currently in ID
uncond_br  in  1  decoder UnCondBr: 1 selects the imm26 offset, 0 selects imm19
pc  out  ADDR_WIDTH  IF-stage PC
pc_id  out  ADDR_WIDTH  PC of the instruction in ID
instruction  out  32  ID-stage instruction to the decoder
instr_one_clock_before  out  32  instruction that was in ID one cycle earlier
instr_two_clocks_before  out  32  instruction that was in ID two cycles earlier
running  out  1  high in RUN and DRAIN
halted  out  1  high in HALTED
fetch_count  out  32  count of non-bubble instructions latched into ID

Behaviour:
- BUBBLE = 32'hFFFFFFFF.
  - Opcode 111111 decodes to all-zero controls.
  - Rd = X31, so the decoder's forwarding logic ignores it.
- Reset (async) values:
  - state = IDLE, pc = RESET_PC, pc_id = 0.
  - instruction and both history registers = BUBBLE.
  - halted = 0, running = 0, fetch_count = 0.
- imem_addr = pc at all times (combinational).
- FSM states: IDLE, RUN, DRAIN, HALTED.
  - IDLE:
    - pc holds; IF/ID and history hold BUBBLE.
    - start -> RUN.
  - RUN, every posedge:
    - instruction <= imem_rdata and pc_id <= pc.
    - Histories shift: instr_two_clocks_before <= instr_one_clock_before; instr_one_clock_before <= instruction.
    - fetch_count increments if imem_rdata != BUBBLE.
  - RUN, next PC:
    - If br_taken: pc <= pc_id + (sext(off) << 2).
      - off = instruction[25:0] when uncond_br = 1.
      - off = instruction[23:5] otherwise.
    - Else: pc <= pc + 4.
    - Arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
  - Delay slot: the word fetched while the branch sits in ID (pc_id+4) is always latched and executed. There is no flush.
  - Halt detection: when instruction == HALT_WORD in RUN, -> DRAIN on that posedge.
    - IF/ID loads BUBBLE instead of the delay-slot word; the halt word has no delay slot.
    - pc is frozen at its current value.
  - DRAIN:
    - IF/ID loads BUBBLE each cycle; histories keep shifting.
    - br_taken is ignored; pc holds.
    - A drain counter loads DRAIN_CYCLES-1 on entry and decrements each cycle; at 0 -> HALTED.
  - HALTED:
    - Everything holds.
    - start -> RUN with pc = RESET_PC, IF/ID and histories = BUBBLE, fetch_count = 0, pc_id = 0.
- start is ignored in RUN and DRAIN.
- br_taken and uncond_br are ignored outside RUN.
- Reset asserted mid-operation returns all state to reset values immediately. No partial drain.
- Latency:
  - Word at address A appears on instruction one posedge after pc = A in RUN.
  - A taken branch in ID redirects pc on the same posedge that latches its delay slot. The target therefore reaches ID two cycles after the branch reached ID.

Test Plan:
- Reset then start, memory holds ADDI words at 0,4,8,12 -> instruction shows word@0 on the 1st RUN edge, word@4 on the 2nd; instr_one_clock_before = word@0 and instr_two_clocks_before = BUBBLE on the 2nd; fetch_count = 2.
- B #3 at 0x8 with uncond_br = br_taken = 1 while it sits in ID -> delay slot word@0xC enters ID next, then word@0x14; pc_id = 0x14.
- CBZ at 0x20 with imm19 = -2 (0x7FFFE), br_taken = 1 -> delay slot @0x24, then target 0x18 in ID.
- CBZ with br_taken = 0 -> sequential fetch continues at 0x24, 0x28.
- HALT_WORD at 0x10 -> delay slot discarded; 4 BUBBLEs enter ID; halted = 1 exactly 4 edges after DRAIN entry; pc frozen; fetch_count excludes bubbles.
- Assert reset in DRAIN, then start from HALTED -> all outputs return to reset values; restart fetches from RESET_PC with fetch_count = 0.
- Start during RUN -> no effect.
